polyvec_acc_scheduler: RTL
==========================

// Module: polyvec_acc_scheduler
// PURPOSE
//  Shares one polyvec_basemul_acc_mont engine between NREQ requesters (matrix-row jobs of A*s).
//  Per granted job: streams KYBER_K poly pairs from the source memory, fires cal_en,
//  waits for engine done, then drains 128 result pairs to the sink with backpressure.
// PARAMETERS
//  DEPTH    8   coef index width (2^DEPTH = 256 coefs, 128 pairs)
//  KYBER_K  3   polys per vector (2..4)
//  NREQ     2   requesters
//  TMO_W    12  watchdog counter width (used only with SCHED_TIMEOUT_EN)
// PORTS
//  clk            in   1           clock, rising edge
//  reset_n        in   1           async active-low reset
//  req            in   NREQ        job request, level; sampled only in IDLE
//  req_row        in   NREQ*4      row id per requester, captured at grant
//  grant          out  NREQ        one-hot, held IDLE-exit..job_done
//  job_done       out  1           1-cycle pulse after last sink beat
//  src_rd         out  1           source read strobe
//  src_sel_b      out  1           0 = matrix A row, 1 = vector s
//  src_row        out  4           captured row id
//  src_poly       out  2           poly index 0..K-1
//  src_addr       out  DEPTH       even coef index (pair base)
//  src_d1/src_d2  in   16 signed   pair data, valid 1 cycle after src_rd
//  eng_set/eng_readin_a/eng_readin_b/eng_cal_en/eng_readout  out 1  engine controls
//  eng_full_in_a/eng_full_in_b  out 1  last-beat markers
//  eng_din_1/eng_din_2  out 16 signed  data to engine (same bus for A and B)
//  eng_index      out  DEPTH       index paired with data
//  eng_done       in   1           engine result ready
//  eng_dout_1/2   in   16 signed   engine result pair
//  snk_valid      out  1           result beat valid
//  snk_ready      in   1           sink accepts
//  snk_d1/snk_d2  out  16 signed   result pair
//  snk_index      out  DEPTH-1     pair index 0..127
//  busy           out  1           state != IDLE
//  err            out  1           sticky timeout flag (0 without SCHED_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; rr pointer = requester 0; counters 0.
//  eng_set = 1 whenever reset_n is high.
//  IDLE -> GRANT when |req; round-robin from pointer; pointer = winner+1 at grant.
//  GRANT (1 cyc): latch row; pulse eng_cal_en (clears engine indices/k); -> LOAD_A, poly=0.
//  LOAD_A: src_rd each cycle, src_addr 0,2..254; data returns +1 cycle -> eng_readin_a=1,
//   eng_index = src_addr delayed 1. full_in_a on beat 127. -> LOAD_B after last return (129 cyc).
//  LOAD_B: same with src_sel_b=1, eng_readin_b, full_in_b on beat 127.
//   Then poly++ ; poly<K-1 -> LOAD_A, else -> WAIT.
//  WAIT: eng_readout=1; hold until eng_done=1 -> DRAIN.
//  DRAIN: snk_valid=1, snk_d = eng_dout, snk_index = pair counter;
//   counter advances only on snk_valid&snk_ready; payload stable while stalled.
//  Last accepted beat (index 127) -> DONE: job_done pulse, grant drops -> IDLE.
//  Pipeline: no bubbles in LOAD except the 1-cycle src latency tail per poly.
//  Simultaneous req from all: rr order strict; a dropped req mid-job is ignored.
//  Async reset mid-job: immediate IDLE, grant 0, no job_done; engine re-cleared on next GRANT.
//  Counters never wrap inside a job; DEPTH-1 pair counter terminates exactly at 127.
// CONFIGURATION
//  SCHED_TIMEOUT_EN defined: WAIT counts cycles; reaching 2^TMO_W-1 without eng_done sets err,
//   pulses job_done, releases grant, -> IDLE. err clears only on reset.
//  Not defined: no counter, WAIT unbounded, err tied 0.
// STRUCTURE
//  kyber_pkg: KYBER_N=256, KYBER_K, KYBER_Q=3329, state localparams
//   (IDLE,GRANT,LOAD_A,LOAD_B,WAIT,DRAIN,DONE), 16-bit coef type.
//  Sub-module: sched_rr_arbiter (NREQ req, enable, one-hot grant, rotating pointer).
//  Rest (FSM, counters, 1-stage src pipeline) flat in this file.
// TESTING
//  req=01, K=3, src ramp: 3x(128 A + 128 B) beats, eng_index 0..254 each, full_in on beat 127.
//  req=11 held: grants 01,10,01 in order; exactly one job_done per job; no grant overlap.
//  DRAIN with snk_ready low on beats 5..9: snk_index stays 5, data stable; 128 beats total.
//  reset_n low during LOAD_B poly 1: next cycle busy=0, grant=0, no job_done; new job restarts at poly 0.
//  SCHED_TIMEOUT_EN, TMO_W=4, eng_done never: err=1 after 15 WAIT cycles, job_done pulses, IDLE.
//  Golden check: random A,s vs C model basemul-acc; all 128 sink pairs equal mod 3329.

Source files
------------

// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber constants, scheduler states and coefficient type
package kyber_pkg;
    localparam int KYBER_N = 256;
    localparam int KYBER_K = 3;
    localparam int KYBER_Q = 3329;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    typedef logic signed [15:0] coef_t;
endpackage

// File: rtl/sched_rr_arbiter.sv
// rtl/sched_rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer moves past each winner
module sched_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_win
);
    logic [PW-1:0] r_ptr;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        o_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[(int'(r_ptr) + i) % NREQ]) begin
                w_found = 1'b1;
                o_grant[(int'(r_ptr) + i) % NREQ] = 1'b1;
                o_win   = PW'((int'(r_ptr) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (i_en && w_found) begin
            r_ptr <= (o_win == PW'(NREQ - 1)) ? '0 : o_win + 1'b1;
        end
    end
endmodule

// File: rtl/polyvec_acc_scheduler.sv
// rtl/polyvec_acc_scheduler.sv - shares one basemul-acc engine between requesters
// Optional watchdog on the engine wait: SCHED_TIMEOUT_EN
module polyvec_acc_scheduler
    import kyber_pkg::*;
#(
    parameter int DEPTH   = $clog2(KYBER_N),
    parameter int KYBER_K = kyber_pkg::KYBER_K,
    parameter int NREQ    = 2,
    parameter int TMO_W   = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*4-1:0]   req_row,
    output logic [NREQ-1:0]     grant,
    output logic                job_done,
    output logic                src_rd,
    output logic                src_sel_b,
    output logic [3:0]          src_row,
    output logic [1:0]          src_poly,
    output logic [DEPTH-1:0]    src_addr,
    input  logic signed [15:0]  src_d1,
    input  logic signed [15:0]  src_d2,
    output logic                eng_set,
    output logic                eng_readin_a,
    output logic                eng_readin_b,
    output logic                eng_cal_en,
    output logic                eng_readout,
    output logic                eng_full_in_a,
    output logic                eng_full_in_b,
    output logic signed [15:0]  eng_din_1,
    output logic signed [15:0]  eng_din_2,
    output logic [DEPTH-1:0]    eng_index,
    input  logic                eng_done,
    input  logic signed [15:0]  eng_dout_1,
    input  logic signed [15:0]  eng_dout_2,
    output logic                snk_valid,
    input  logic                snk_ready,
    output logic signed [15:0]  snk_d1,
    output logic signed [15:0]  snk_d2,
    output logic [DEPTH-2:0]    snk_index,
    output logic                busy,
    output logic                err
);
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NPAIR = 2 ** (DEPTH - 1);

    sched_state_t     r_state;
    logic [NREQ-1:0]  r_grant;
    logic [3:0]       r_row;
    logic [1:0]       r_poly;
    logic [DEPTH-1:0] r_cnt;
    logic             r_rd_d;
    logic             r_sel_d;
    logic [DEPTH-1:0] r_addr_d;
    logic [NREQ-1:0]  w_gnt;
    logic [PW-1:0]    w_win;
    logic             w_load;
    logic             w_last_pair;

    sched_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (req),
        .i_en    (r_state == S_IDLE),
        .o_grant (w_gnt),
        .o_win   (w_win)
    );

    assign w_load      = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign w_last_pair = (r_cnt == DEPTH'(NPAIR - 1));

    // Reads issue while the pair counter is below NPAIR; the extra cycle collects the last return.
    assign src_rd    = w_load && (r_cnt < DEPTH'(NPAIR));
    assign src_sel_b = (r_state == S_LOAD_B);
    assign src_addr  = src_rd ? {r_cnt[DEPTH-2:0], 1'b0} : '0;
    assign src_row   = r_row;
    assign src_poly  = r_poly;

    assign eng_set       = reset_n;
    assign eng_cal_en    = (r_state == S_GRANT);
    assign eng_readin_a  = r_rd_d && !r_sel_d;
    assign eng_readin_b  = r_rd_d && r_sel_d;
    assign eng_full_in_a = eng_readin_a && (r_addr_d == DEPTH'(2 * NPAIR - 2));
    assign eng_full_in_b = eng_readin_b && (r_addr_d == DEPTH'(2 * NPAIR - 2));
    assign eng_din_1     = r_rd_d ? src_d1 : '0;
    assign eng_din_2     = r_rd_d ? src_d2 : '0;
    // During DRAIN the engine result is addressed by the pair counter, so it holds under stall.
    assign eng_index     = (r_state == S_DRAIN) ? {r_cnt[DEPTH-2:0], 1'b0} : r_addr_d;
    assign eng_readout   = (r_state == S_WAIT) || (r_state == S_DRAIN);

    assign snk_valid = (r_state == S_DRAIN);
    assign snk_d1    = snk_valid ? eng_dout_1 : '0;
    assign snk_d2    = snk_valid ? eng_dout_2 : '0;
    assign snk_index = snk_valid ? r_cnt[DEPTH-2:0] : '0;

    assign grant    = r_grant;
    assign job_done = (r_state == S_DONE);
    assign busy     = (r_state != S_IDLE);

`ifdef SCHED_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo;
    logic             r_err;
    assign err = r_err;
`else
    assign err = (TMO_W == 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_row    <= '0;
            r_poly   <= '0;
            r_cnt    <= '0;
            r_rd_d   <= 1'b0;
            r_sel_d  <= 1'b0;
            r_addr_d <= '0;
`ifdef SCHED_TIMEOUT_EN
            r_tmo    <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_rd_d   <= src_rd;
            r_sel_d  <= src_sel_b;
            r_addr_d <= src_addr;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_grant <= w_gnt;
                        r_row   <= req_row[int'(w_win) * 4 +: 4];
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_poly  <= '0;
                    r_cnt   <= '0;
                    r_state <= S_LOAD_A;
                end
                S_LOAD_A: begin
                    if (r_cnt == DEPTH'(NPAIR)) begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD_B;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LOAD_B: begin
                    if (r_cnt == DEPTH'(NPAIR)) begin
                        r_cnt <= '0;
                        if (r_poly == 2'(KYBER_K - 1)) begin
                            r_state <= S_WAIT;
`ifdef SCHED_TIMEOUT_EN
                            r_tmo   <= '0;
`endif
                        end else begin
                            r_poly  <= r_poly + 1'b1;
                            r_state <= S_LOAD_A;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (eng_done) begin
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (r_tmo == {{(TMO_W - 1){1'b1}}, 1'b0}) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (snk_ready) begin
                        if (w_last_pair) begin
                            r_cnt   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
